// File: rtl/z80m_pkg.sv
// Shared types and constants for the Z80-style bus initiator.
// States R1/R2 exist only when Z80M_REFRESH_EN is defined.
package z80m_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
`ifdef Z80M_REFRESH_EN
    S_HOLD = 3'd5,
    S_R1   = 3'd6,
    S_R2   = 3'd7
`else
    S_HOLD = 3'd5
`endif
  } z80m_state_e;

  localparam logic [7:0] PPI_BASE  = 8'hA8;
  localparam logic [1:0] PORT_A    = 2'd0;
  localparam logic [1:0] PORT_B    = 2'd1;
  localparam logic [1:0] PORT_C    = 2'd2;
  localparam logic [1:0] PORT_CTRL = 2'd3;

  localparam int TDIV_W = 8;

  localparam int RCNT_W = 7;

endpackage

// File: rtl/z80m_tstate_timer.sv
// T-state prescaler: tick marks the last clock of a T-state.
// Restarts whenever the bus FSM changes state.
module z80m_tstate_timer
  import z80m_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic tick
);

  localparam logic [TDIV_W-1:0] LAST = TDIV_W'(CLK_DIV - 1);

  logic [TDIV_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (RST || restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/z80_bus_master.sv
// Z80-style bus initiator: single-word I/O and memory cycles.
// Define Z80M_REFRESH_EN to append R1/R2 refresh states to memory cycles.
module z80_bus_master
  import z80m_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_IO,
  input  logic        CMD_WR,
  input  logic [15:0] CMD_ADDR,
  input  logic [7:0]  CMD_DATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic [15:0] A,
  output logic [7:0]  DOUT,
  output logic        DOE,
  input  logic [7:0]  DIN,
  output logic        MREQb,
  output logic        IORQb,
  output logic        RDb,
  output logic        WRb,
  output logic        RFSHb,
  input  logic        WAITb
);

  z80m_state_e state_q, state_d;

  logic [2:0]  pend_q, pend_d;
  logic [2:0]  pend_nx;
  logic        cmd_io_q;
  logic        cmd_wr_q;
  logic [15:0] a_q;
  logic [7:0]  dout_q;
  logic        doe_q;
  logic [7:0]  rsp_q;
  logic        tick;
  logic        strobe_on;
  logic        accept;

`ifdef Z80M_REFRESH_EN
  logic [RCNT_W-1:0] r_q;
`endif

  z80m_tstate_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .restart (state_d != state_q),
    .tick    (tick)
  );

  assign accept = (state_q == S_IDLE) && CMD_VALID;

  // pend counts TW states still owed after the current one
  assign pend_nx = pend_q + {2'b00, ~WAITb};

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          state_d = S_T1;
          pend_d  = CMD_IO ? 3'(WAIT_CYCLES) : 3'd0;
        end
      end
      S_T1: begin
        if (tick) state_d = S_T2;
      end
      S_T2, S_TW: begin
        if (tick) begin
          if (pend_nx != 3'd0) begin
            state_d = S_TW;
            pend_d  = pend_nx - 3'd1;
          end else begin
            state_d = S_T3;
          end
        end
      end
      S_T3: begin
        if (tick) state_d = S_HOLD;
      end
      S_HOLD: begin
`ifdef Z80M_REFRESH_EN
        state_d = cmd_io_q ? S_IDLE : S_R1;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef Z80M_REFRESH_EN
      S_R1: begin
        if (tick) state_d = S_R2;
      end
      S_R2: begin
        if (tick) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      cmd_io_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      a_q      <= '0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        cmd_io_q <= CMD_IO;
        cmd_wr_q <= CMD_WR;
        a_q      <= CMD_ADDR;
        if (CMD_WR) begin
          dout_q <= CMD_DATA;
          doe_q  <= 1'b1;
        end
      end
      if (state_q == S_T3 && tick && !cmd_wr_q) begin
        rsp_q <= DIN;
      end
      if (state_q == S_HOLD) begin
        doe_q <= 1'b0;
      end
`ifdef Z80M_REFRESH_EN
      if (state_q == S_HOLD && state_d == S_R1) begin
        a_q <= {9'b0, r_q};
      end
`endif
    end
  end

`ifdef Z80M_REFRESH_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else if (state_q == S_R2 && tick) begin
      r_q <= r_q + 1'b1;
    end
  end
`endif

  assign strobe_on = (state_q == S_T2) ||
                     (state_q == S_TW) ||
                     (state_q == S_T3);

  assign CMD_READY = (state_q == S_IDLE);
  assign RSP_VALID = (state_q == S_HOLD);
  assign RSP_DATA  = rsp_q;
  assign A         = a_q;
  assign DOUT      = dout_q;
  assign DOE       = doe_q;

  assign IORQb = ~(strobe_on & cmd_io_q);
  assign RDb   = ~(strobe_on & ~cmd_wr_q);
  assign WRb   = ~(strobe_on & cmd_wr_q);

`ifdef Z80M_REFRESH_EN
  assign MREQb = ~((strobe_on & ~cmd_io_q) | (state_q == S_R2));
  assign RFSHb = ~((state_q == S_R1) | (state_q == S_R2));
`else
  assign MREQb = ~(strobe_on & ~cmd_io_q);
  assign RFSHb = 1'b1;
`endif

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master with a response scoreboard.
// Refresh checks are active when Z80M_REFRESH_EN is defined.
module tb_z80_bus_master;
  import z80m_pkg::*;

  localparam int D = 2;
  localparam int W = 1;

  logic        CLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_IO;
  logic        CMD_WR;
  logic [15:0] CMD_ADDR;
  logic [7:0]  CMD_DATA;
  logic        RSP_VALID;
  logic [7:0]  RSP_DATA;
  logic [15:0] A;
  logic [7:0]  DOUT;
  logic        DOE;
  logic [7:0]  DIN;
  logic        MREQb;
  logic        IORQb;
  logic        RDb;
  logic        WRb;
  logic        RFSHb;
  logic        WAITb;

  z80_bus_master #(
    .CLK_DIV     (D),
    .WAIT_CYCLES (W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_IO    (CMD_IO),
    .CMD_WR    (CMD_WR),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_DATA  (CMD_DATA),
    .RSP_VALID (RSP_VALID),
    .RSP_DATA  (RSP_DATA),
    .A         (A),
    .DOUT      (DOUT),
    .DOE       (DOE),
    .DIN       (DIN),
    .MREQb     (MREQb),
    .IORQb     (IORQb),
    .RDb       (RDb),
    .WRb       (WRb),
    .RFSHb     (RFSHb),
    .WAITb     (WAITb)
  );

  typedef struct {
    int         lat;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  logic [7:0] model_rd;
  logic [7:0] ppi_rega;
  logic [6:0] rcnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input int n);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_spurious_rsp"}, 32'(RSP_VALID), 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_rsp_data"}, 32'(RSP_DATA), 32'(e.data));
    end
  endtask

  task automatic run_cmd(input string tag, input bit io,
                         input bit wr, input logic [15:0] addr,
                         input logic [7:0] data,
                         input logic [7:0] din, input int wts);
    int tw, lat, strb, iorq_n, mreq_n, rd_n, wr_n, rf_n;
    int both_n, rl, ml, ab, rw;
    bit got;
    tw     = io ? W + wts : 0;
    lat    = (3 + tw) * D + 1;
    strb   = (2 + tw) * D;
    iorq_n = 0; mreq_n = 0; rd_n = 0; wr_n = 0;
    rf_n   = 0; both_n = 0; got = 1'b0;
    @(negedge CLK);
    chk({tag, "_ready_idle"}, 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1;
    CMD_IO    = io;
    CMD_WR    = wr;
    CMD_ADDR  = addr;
    CMD_DATA  = data;
    DIN       = din;
    WAITb     = 1'b1;
    if (!wr) model_rd = din;
    sb.push_back('{lat: lat, data: model_rd});
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_ADDR  = ~addr;
    CMD_DATA  = ~data;
    for (int n = 1; n <= lat + 8 && !got; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        chk({tag, "_ready_busy"}, 32'(CMD_READY), 32'd0);
        chk({tag, "_t1_addr"}, 32'(A), 32'(addr));
        chk({tag, "_t1_doe"}, 32'(DOE), 32'(wr));
      end
      if (!IORQb) iorq_n++;
      if (!MREQb) mreq_n++;
      if (!RDb) rd_n++;
      if (!WRb) wr_n++;
      if (!RFSHb) rf_n++;
      if (!IORQb && !MREQb) both_n++;
      if (!IORQb && !WRb && A[7:2] == PPI_BASE[7:2] &&
          A[1:0] == PORT_A) ppi_rega = DOUT;
      if (RSP_VALID) begin
        got = 1'b1;
        pop_chk(tag, n);
        chk({tag, "_hold_strobes"},
            32'({MREQb, IORQb, RDb, WRb}), 32'hF);
        chk({tag, "_hold_addr"}, 32'(A), 32'(addr));
        if (wr) begin
          chk({tag, "_hold_doe"}, 32'(DOE), 32'd1);
          chk({tag, "_hold_dout"}, 32'(DOUT), 32'(data));
        end
      end
      WAITb = !(n > D && n <= D + D * wts);
    end
    WAITb = 1'b1;
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    chk({tag, "_iorq_low"}, iorq_n, io ? strb : 0);
    chk({tag, "_mreq_low"}, mreq_n, io ? 0 : strb);
    chk({tag, "_rd_low"}, rd_n, wr ? 0 : strb);
    chk({tag, "_wr_low"}, wr_n, wr ? strb : 0);
    chk({tag, "_rfsh_main"}, rf_n, 0);
    chk({tag, "_excl"}, both_n, 0);
    rl = 0; ml = 0; ab = 0; rw = 0;
`ifdef Z80M_REFRESH_EN
    if (!io) begin
      for (int k = 0; k < 2 * D; k++) begin
        @(negedge CLK);
        if (k == 0) chk({tag, "_post_doe"}, 32'(DOE), 32'd0);
        if (!RFSHb) rl++;
        if (!MREQb) ml++;
        if (A !== {9'b0, rcnt}) ab++;
        if (!RDb || !WRb) rw++;
      end
      chk({tag, "_rfsh_low"}, rl, 2 * D);
      chk({tag, "_rfsh_mreq"}, ml, D);
      chk({tag, "_rfsh_addr"}, ab, 0);
      chk({tag, "_rfsh_rdwr"}, rw, 0);
      rcnt = rcnt + 7'd1;
      @(negedge CLK);
    end else begin
      @(negedge CLK);
      chk({tag, "_post_doe"}, 32'(DOE), 32'd0);
    end
`else
    @(negedge CLK);
    chk({tag, "_post_doe"}, 32'(DOE), 32'd0);
`endif
    chk({tag, "_back_idle"}, 32'(CMD_READY), 32'd1);
  endtask

  initial begin
    int h1, rv, busy;
    bit got2;
    checks    = 0;
    errors    = 0;
    model_rd  = 8'h00;
    ppi_rega  = 8'h00;
    rcnt      = 7'd0;
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_IO    = 1'b0;
    CMD_WR    = 1'b0;
    CMD_ADDR  = 16'h0;
    CMD_DATA  = 8'h0;
    DIN       = 8'h0;
    WAITb     = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("rst_addr", 32'(A), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_doe", 32'(DOE), 32'd0);
    chk("rst_strobes",
        32'({MREQb, IORQb, RDb, WRb, RFSHb}), 32'h1F);
    RST = 1'b0;

    run_cmd("io_wr_a8", 1'b1, 1'b1, 16'h00A8, 8'hAA, 8'h00, 0);
    chk("ppi_rega", 32'(ppi_rega), 32'hAA);
    run_cmd("io_rd_a9", 1'b1, 1'b0, 16'h00A9, 8'h00, 8'h3C, 0);
    run_cmd("io_rd_wait", 1'b1, 1'b0, 16'h00AA, 8'h00, 8'hC3, 2);
    run_cmd("mem_wr_8000", 1'b0, 1'b1, 16'h8000, 8'h12, 8'h00, 0);
    run_cmd("mem_rd_4001", 1'b0, 1'b0, 16'h4001, 8'h00, 8'h99, 0);

    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_IO    = 1'b1;
    CMD_WR    = 1'b0;
    CMD_ADDR  = 16'h00AB;
    DIN       = 8'h77;
    model_rd  = 8'h77;
    sb.push_back('{lat: 9, data: 8'h77});
    @(posedge CLK);
    #1;
    h1 = 0;
    got2 = 1'b0;
    for (int n = 1; n <= 40 && !got2; n++) begin
      @(negedge CLK);
      if (h1 != 0 && n == h1 + 1)
        chk("b2b_idle_ready", 32'(CMD_READY), 32'd1);
      if (h1 != 0 && n == h1 + 2) begin
        chk("b2b_busy", 32'(CMD_READY), 32'd0);
        chk("b2b_addr", 32'(A), 32'h1234);
        CMD_VALID = 1'b0;
        CMD_ADDR  = 16'hFFFF;
      end
      if (RSP_VALID) begin
        pop_chk("b2b", n);
        if (h1 == 0) begin
          h1       = n;
          CMD_IO   = 1'b0;
          CMD_ADDR = 16'h1234;
          DIN      = 8'h5A;
          model_rd = 8'h5A;
          sb.push_back('{lat: n + 1 + 3 * D + 1, data: 8'h5A});
        end else begin
          got2 = 1'b1;
        end
      end
    end
    chk("b2b_done", 32'(got2), 32'd1);
    busy = 0;
    for (int n = 0; n < 20 && !CMD_READY; n++) begin
      @(negedge CLK);
      busy++;
    end
    chk("b2b_drain", 32'(CMD_READY), 32'd1);
`ifdef Z80M_REFRESH_EN
    rcnt = rcnt + 7'd1;
`endif

    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_IO    = 1'b1;
    CMD_WR    = 1'b1;
    CMD_ADDR  = 16'h00A8;
    CMD_DATA  = 8'h55;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    repeat (D + 1) @(negedge CLK);
    chk("abort_pre_iorq", 32'(IORQb), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_strobes",
        32'({MREQb, IORQb, RDb, WRb, RFSHb}), 32'h1F);
    chk("abort_doe", 32'(DOE), 32'd0);
    chk("abort_ready", 32'(CMD_READY), 32'd1);
    chk("abort_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("abort_rsp_data", 32'(RSP_DATA), 32'd0);
    RST = 1'b0;
    model_rd = 8'h00;
    rcnt = 7'd0;
    rv = 0;
    repeat (12) begin
      @(negedge CLK);
      if (RSP_VALID) rv++;
    end
    chk("abort_no_rsp", rv, 0);

    run_cmd("io_wr_recover", 1'b1, 1'b1, 16'h00A8, 8'h0F, 8'h00, 0);
    chk("ppi_rega_recover", 32'(ppi_rega), 32'h0F);
    run_cmd("mem_wr_after", 1'b0, 1'b1, 16'h8000, 8'h12, 8'h00, 0);

`ifdef Z80M_REFRESH_EN
    for (int i = 0; i < 129; i++) begin
      run_cmd("mem_wrap", 1'b0, 1'b0, 16'(16'h2000 + i),
              8'h00, 8'(i), 0);
    end
    chk("rcnt_wrapped", 32'(rcnt), 32'd2);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
